// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: and/or/add/sub/set-less-than on WIDTH-bit operands.
// Zero latency; purely combinational, no flow control.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        unique case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU adder, one bit per cycle.
// Latency WIDTH cycles start-edge to done; new starts are accepted only while ready (IDLE).
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] CTRL_ADD = ALU_ADD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    seq_state_e       state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] count_q,   count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;

        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // Final iteration: capture the updated accumulator, park the counter.
                if (count_q == LAST_ITER) begin
                    product_d = acc_d;
                    count_d   = '0;
                    state_d   = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    assign ready    = (state_q == SEQ_IDLE);
    assign busy     = (state_q == SEQ_RUN);
    assign done     = (state_q == SEQ_DONE);
    assign product  = product_q;
    assign alu_a    = acc_q;
    assign alu_b    = mcand_q;
    assign alu_ctrl = CTRL_ADD;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    int n_total;
    int n_pass;
    logic [31:0] last_product;

    alu_mul_sequencer #(.WIDTH(32), .CTRL_ADD(4'b0010)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    alu #(.WIDTH(32)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string nm);
        int   lat;
        logic saw_ready, bad_ctrl, prod_moved, not_busy;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        lat = 0;
        saw_ready = 0; bad_ctrl = 0; prod_moved = 0; not_busy = 0;
        while (!done && lat < 40) begin
            if (ready) saw_ready = 1;
            if (!busy) not_busy = 1;
            if (alu_ctrl !== 4'b0010) bad_ctrl = 1;
            if (product !== last_product) prod_moved = 1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({nm, " latency"}, lat, 32);
        check({nm, " product"}, product, exp);
        check({nm, " ready low in RUN"}, {31'd0, saw_ready}, 32'd0);
        check({nm, " busy high in RUN"}, {31'd0, not_busy}, 32'd0);
        check({nm, " alu_ctrl add"}, {31'd0, bad_ctrl | (alu_ctrl !== 4'b0010)}, 32'd0);
        check({nm, " product held"}, {31'd0, prod_moved}, 32'd0);
        last_product = exp;
        @(posedge clk);
        @(negedge clk);
        check({nm, " done one cycle"}, {31'd0, done}, 32'd0);
        check({nm, " back to idle"}, {31'd0, ready}, 32'd1);
        check({nm, " product after done"}, product, exp);
    endtask

    initial begin
        int first_done, second_done, n_done;
        logic [31:0] p1, p2;
        n_total = 0;
        n_pass  = 0;
        last_product = 32'd0;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;

        vecs[0] = '{32'd3,         32'd5,         32'd15,         "3x5"};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,   "ffx ff wrap"};
        vecs[2] = '{32'h12345678,  32'd0,         32'd0,          "x by zero"};
        vecs[3] = '{32'h00010000,  32'h00010000,  32'd0,          "2^16 sq"};
        vecs[4] = '{32'd65535,     32'd65537,     32'hFFFFFFFF,   "65535x65537"};
        vecs[5] = '{32'hDEADBEEF,  32'd1,         32'hDEADBEEF,   "x by one"};
        vecs[6] = '{32'h80000000,  32'd2,         32'd0,          "msb drop"};
        vecs[7] = '{32'd1000,      32'd1000,      32'd1000000,    "1000 sq"};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", product, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // start held high: operands changed mid-RUN must be ignored, re-accept at E34
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        @(posedge clk);
        first_done = -1; second_done = -1; n_done = 0; p1 = 0; p2 = 0;
        for (int k = 1; k <= 72; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin op_a = 32'd9; op_b = 32'd9; end
            if (k == 40) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) begin first_done = k; p1 = product; end
                else if (second_done < 0) begin second_done = k; p2 = product; end
            end
        end
        check("held start first done cycle", first_done, 32);
        check("held start first product", p1, 32'd42);
        check("held start second done cycle", second_done, 66);
        check("held start second product", p2, 32'd81);
        check("held start done count", n_done, 2);

        // reset during iteration 10
        @(negedge clk);
        op_a = 32'd100; op_b = 32'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid reset ready", {31'd0, ready}, 32'd1);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset product", product, 32'd0);
        check("mid reset alu_a", alu_a, 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid reset no done", n_done, 0);

        // reset and start on the same edge: reset wins
        op_a = 32'd4; op_b = 32'd4; start = 1'b1; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check("reset+start ready", {31'd0, ready}, 32'd1);
        check("reset+start busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
